// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the CPU datapath and a word-organised
// data memory. Accepts one byte-addressed request at a time, checks alignment
// and range, performs loads with sign/zero extension, and runs sub-word stores
// as read-modify-write sequences.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   req, op, vaddr  request strobe, operation, byte address (sampled in IDLE)
//   wdata, pc       store data and requesting pc (sampled with req)
//   busy, done      not-idle flag; one-cycle completion pulse
//   rdata           extended load result (changes only on successful loads)
//   adel, ades      load/store address error, valid while done is high
//   mem_we, mem_addr, mem_wdata, mem_pc   memory word port and write-trace pc
//   mem_rdata       memory read data, combinational from mem_addr
module lsu_ctrl #(
    parameter int unsigned MEM_WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] vaddr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MERGE,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [15:0] wd_q;
    logic        err_ld_q, err_st_q;

    logic        is_store, req_err, accept;
    logic [15:0] half;
    logic [7:0]  byt;
    logic [31:0] load_word, merge_word;

    // Request classification on the raw inputs (only used in IDLE).
    always_comb begin
        is_store = (op >= OP_SW);
        req_err  = (vaddr >= ADDR_LIMIT);
        if ((op == OP_LW || op == OP_SW) && (vaddr[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
        if ((op == OP_LH || op == OP_LHU || op == OP_SH) && vaddr[0]) begin
            req_err = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_RESP);
        mem_we  = (state_q == ST_WRITE);
        adel    = (state_q == ST_RESP) && err_ld_q;
        ades    = (state_q == ST_RESP) && err_st_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (req_err)        state_d = ST_RESP;
                    else if (!is_store) state_d = ST_LOAD;
                    else if (op == OP_SW) state_d = ST_WRITE;
                    else                state_d = ST_MERGE;
                end
            end
            ST_LOAD:  state_d = ST_RESP;
            ST_MERGE: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Load extraction and sub-word merge from the current memory word.
    always_comb begin
        half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        byt  = 8'(mem_rdata >> {off_q, 3'b000});
        case (op_q)
            OP_LH:   load_word = {{16{half[15]}}, half};
            OP_LHU:  load_word = {16'h0000, half};
            OP_LB:   load_word = {{24{byt[7]}}, byt};
            OP_LBU:  load_word = {24'h000000, byt};
            default: load_word = mem_rdata;
        endcase
        if (op_q == OP_SH) begin
            merge_word = off_q[1] ? {wd_q, mem_rdata[15:0]}
                                  : {mem_rdata[31:16], wd_q};
        end else begin
            case (off_q)
                2'd0:    merge_word = {mem_rdata[31:8], wd_q[7:0]};
                2'd1:    merge_word = {mem_rdata[31:16], wd_q[7:0], mem_rdata[7:0]};
                2'd2:    merge_word = {mem_rdata[31:24], wd_q[7:0], mem_rdata[15:0]};
                default: merge_word = {wd_q[7:0], mem_rdata[23:0]};
            endcase
        end
    end

    // Request latches and registered datapath outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= 3'd0;
            off_q     <= 2'd0;
            wd_q      <= 16'h0000;
            err_ld_q  <= 1'b0;
            err_st_q  <= 1'b0;
            rdata     <= 32'h0;
            mem_addr  <= 12'h000;
            mem_wdata <= 32'h0;
            mem_pc    <= 32'h0;
        end else begin
            if (accept) begin
                op_q     <= op;
                off_q    <= vaddr[1:0];
                wd_q     <= wdata[15:0];
                err_ld_q <= req_err && !is_store;
                err_st_q <= req_err && is_store;
                mem_addr <= vaddr[13:2];
                mem_pc   <= pc;
                if (op == OP_SW) begin
                    mem_wdata <= wdata;
                end
            end
            if (state_q == ST_LOAD) begin
                rdata <= load_word;
            end
            if (state_q == ST_MERGE) begin
                mem_wdata <= merge_word;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: table of requests checked through a scoreboard,
// plus hand-written sequences for a held request and reset during WRITE.
module tb_lsu_ctrl;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] vaddr = 32'h0, wdata = 32'h0, pc = 32'h0;
    logic        busy, done, adel, ades, mem_we;
    logic [31:0] rdata, mem_wdata, mem_pc, mem_rdata;
    logic [11:0] mem_addr;

    logic [31:0] mem [0:3071];
    logic        preload = 1'b1;

    lsu_ctrl #(.MEM_WORDS(3072)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .vaddr(vaddr),
        .wdata(wdata), .pc(pc), .busy(busy), .done(done), .rdata(rdata),
        .adel(adel), .ades(ades), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_pc(mem_pc), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write at the rising edge.
    assign mem_rdata = (mem_addr < 12'd3072) ? mem[mem_addr] : 32'h0;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 3072; i++) mem[i] <= 32'h0;
            mem[12'hBFF] <= 32'h8000_0000;
            mem[12'h010] <= 32'h1122_3344;
        end else if (mem_we && mem_addr < 12'd3072) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected here", name);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] vaddr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_adel;
        logic        exp_ades;
        int          lat;
        int          we_cyc;
        logic [31:0] exp_mw;
    } vec_t;

    typedef struct {
        vec_t        v;
        int          t0;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    logic mon_en = 1'b0;
    logic we_seen = 1'b0;

    // Scoreboard monitor: compares write and completion events against the
    // oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_mem_we");
                end else begin
                    check("we_cycle", 32'(cyc - q[0].t0), 32'(q[0].v.we_cyc));
                    check("mem_wdata", mem_wdata, q[0].v.exp_mw);
                    check("mem_addr", {20'h0, mem_addr}, {20'h0, q[0].v.vaddr[13:2]});
                    we_seen = 1'b1;
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_latency", 32'(cyc - e.t0), 32'(e.v.lat));
                    check("rdata", rdata, e.v.exp_rdata);
                    check("adel", 32'(adel), 32'(e.v.exp_adel));
                    check("ades", 32'(ades), 32'(e.v.exp_ades));
                    check("mem_pc", mem_pc, e.pc);
                    check("we_seen", 32'(we_seen), 32'(e.v.we_cyc >= 0));
                    we_seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input vec_t v, input logic [31:0] p);
        exp_t e;
        @(posedge clk); #1;
        req = 1'b1; op = v.op; vaddr = v.vaddr; wdata = v.wdata; pc = p;
        e.v = v; e.t0 = cyc; e.pc = p;
        q.push_back(e);
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            fail_now("done_timeout");
            q.delete();
        end
    endtask

    vec_t vecs[20];
    int   writes;

    initial begin
        // op, vaddr, wdata, rdata, adel, ades, latency, we cycle, written word
        vecs[0]  = '{SW,  32'h10,   32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 2,  1, 32'h1234_5678};
        vecs[1]  = '{LW,  32'h10,   32'h0,         32'h1234_5678, 1'b0, 1'b0, 2, -1, 32'h0};
        vecs[2]  = '{SB,  32'h11,   32'h5555_55AB, 32'h1234_5678, 1'b0, 1'b0, 3,  2, 32'h1234_AB78};
        vecs[3]  = '{LB,  32'h11,   32'h0,         32'hFFFF_FFAB, 1'b0, 1'b0, 2, -1, 32'h0};
        vecs[4]  = '{LBU, 32'h11,   32'h0,         32'h0000_00AB, 1'b0, 1'b0, 2, -1, 32'h0};
        vecs[5]  = '{SW,  32'h10,   32'h1234_5678, 32'h0000_00AB, 1'b0, 1'b0, 2,  1, 32'h1234_5678};
        vecs[6]  = '{SH,  32'h12,   32'hCCCC_8001, 32'h0000_00AB, 1'b0, 1'b0, 3,  2, 32'h8001_5678};
        vecs[7]  = '{LH,  32'h12,   32'h0,         32'hFFFF_8001, 1'b0, 1'b0, 2, -1, 32'h0};
        vecs[8]  = '{LHU, 32'h12,   32'h0,         32'h0000_8001, 1'b0, 1'b0, 2, -1, 32'h0};
        vecs[9]  = '{LH,  32'h10,   32'h0,         32'h0000_5678, 1'b0, 1'b0, 2, -1, 32'h0};
        vecs[10] = '{LW,  32'h13,   32'h0,         32'h0000_5678, 1'b1, 1'b0, 1, -1, 32'h0};
        vecs[11] = '{SH,  32'h11,   32'hFFFF_FFFF, 32'h0000_5678, 1'b0, 1'b1, 1, -1, 32'h0};
        vecs[12] = '{SW,  32'h3000, 32'hDEAD_BEEF, 32'h0000_5678, 1'b0, 1'b1, 1, -1, 32'h0};
        vecs[13] = '{LB,  32'h2FFF, 32'h0,         32'hFFFF_FF80, 1'b0, 1'b0, 2, -1, 32'h0};
        vecs[14] = '{SB,  32'h2FFD, 32'h0000_007F, 32'hFFFF_FF80, 1'b0, 1'b0, 3,  2, 32'h8000_7F00};
        vecs[15] = '{LB,  32'h2FFD, 32'h0,         32'h0000_007F, 1'b0, 1'b0, 2, -1, 32'h0};
        vecs[16] = '{LW,  32'hFFFF_FFFC, 32'h0,    32'h0000_007F, 1'b1, 1'b0, 1, -1, 32'h0};
        vecs[17] = '{SB,  32'h10,   32'h0000_00EE, 32'h0000_007F, 1'b0, 1'b0, 3,  2, 32'h8001_56EE};
        vecs[18] = '{LHU, 32'h10,   32'h0,         32'h0000_56EE, 1'b0, 1'b0, 2, -1, 32'h0};
        vecs[19] = '{LB,  32'h13,   32'h0,         32'hFFFF_FF80, 1'b0, 1'b0, 2, -1, 32'h0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_adel", 32'(adel), 32'h0);
        check("rst_ades", 32'(ades), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_pc", mem_pc, 32'h0);
        reset = 1'b0;
        preload = 1'b0;

        // Table-driven requests through the scoreboard.
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) issue(vecs[i], 32'h0040_0000 + 32'(4 * i));
        @(negedge clk);
        mon_en = 1'b0;
        check("mem_word_0x10", mem[12'h004], 32'h8001_56EE);
        check("mem_word_0x2ffc", mem[12'hBFF], 32'h8000_7F00);

        // req held high for 10 cycles with sw: one write every 3 cycles.
        writes = 0;
        @(posedge clk); #1;
        req = 1'b1; op = SW; vaddr = 32'h20; wdata = 32'hA5A5_0001; pc = 32'h0040_1000;
        for (int n = 0; n <= 10; n++) begin
            @(negedge clk);
            check("held_mem_we", 32'(mem_we), 32'(n % 3 == 1));
            check("held_busy", 32'(busy), 32'(n % 3 != 0));
            if (mem_we) writes++;
            if (n == 9) begin
                @(posedge clk); #1;
                req = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        check("held_write_count", 32'(writes), 32'd4);
        check("held_idle_busy", 32'(busy), 32'h0);
        check("held_mem_word", mem[12'h008], 32'hA5A5_0001);

        // Reset asserted during WRITE of an sb: no commit, no done pulse.
        @(posedge clk); #1;
        req = 1'b1; op = SB; vaddr = 32'h41; wdata = 32'h99; pc = 32'h0040_2000;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_mem_we", 32'(mem_we), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("rst_write_mem_we", 32'(mem_we), 32'h0);
        check("rst_write_busy", 32'(busy), 32'h0);
        check("rst_write_done", 32'(done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_write_mem_word", mem[12'h010], 32'h1122_3344);
        check("rst_write_rdata", rdata, 32'h0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("rst_write_no_done", 32'(done), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
